// File: rtl/mem_arbiter.sv
// Two-port arbiter (CPU, DMA) in front of a single shared memory-mapped store.
// Each access takes IDLE -> GNT -> ACK. A starvation counter forces the DMA through after STARVE_MAX CPU wins.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [14:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,

    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [14:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic        dma_ack,
    output logic [15:0] dma_rdata,

    output logic [14:0] mem_addr,
    output logic [15:0] mem_in,
    output logic        mem_load,
    input  logic [15:0] mem_out,
    output logic        wr_err
);

    localparam int          CW      = $clog2(STARVE_MAX + 1);
    localparam logic [14:0] RO_BASE = 15'd24576;

    typedef enum logic [1:0] {
        IDLE,
        GNT_CPU,
        GNT_DMA,
        ACK
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_starveCnt;
    logic          r_cpuAck;
    logic          r_dmaAck;
    logic [15:0]   r_cpuRdata;
    logic [15:0]   r_dmaRdata;
    logic [14:0]   r_memAddr;
    logic [15:0]   r_memIn;
    logic          r_memLoad;
    logic          r_wrErr;

    logic w_cpuInRange;
    logic w_dmaInRange;
    logic w_starved;
    logic w_pickDma;

    // Addresses at or above RO_BASE (keyboard and beyond) are read-only.
    assign w_cpuInRange = (cpu_addr < RO_BASE);
    assign w_dmaInRange = (dma_addr < RO_BASE);
    assign w_starved    = (r_starveCnt >= CW'(STARVE_MAX));
    assign w_pickDma    = dma_req && (!cpu_req || w_starved);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_starveCnt <= '0;
            r_cpuAck    <= 1'b0;
            r_dmaAck    <= 1'b0;
            r_cpuRdata  <= '0;
            r_dmaRdata  <= '0;
            r_memAddr   <= '0;
            r_memIn     <= '0;
            r_memLoad   <= 1'b0;
            r_wrErr     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pickDma) begin
                        r_state     <= GNT_DMA;
                        r_starveCnt <= '0;
                        r_memAddr   <= dma_addr;
                        r_memIn     <= dma_wdata;
                        r_memLoad   <= dma_we && w_dmaInRange;
                    end else if (cpu_req) begin
                        r_state <= GNT_CPU;
                        if (dma_req && !w_starved) begin
                            r_starveCnt <= r_starveCnt + CW'(1);
                        end
                        r_memAddr <= cpu_addr;
                        r_memIn   <= cpu_wdata;
                        r_memLoad <= cpu_we && w_cpuInRange;
                    end
                end
                // Requesters hold their inputs until ack, so the write flag is still valid here.
                GNT_CPU: begin
                    r_cpuRdata <= mem_out;
                    r_cpuAck   <= 1'b1;
                    r_wrErr    <= cpu_we && !w_cpuInRange;
                    r_memLoad  <= 1'b0;
                    r_state    <= ACK;
                end
                GNT_DMA: begin
                    r_dmaRdata <= mem_out;
                    r_dmaAck   <= 1'b1;
                    r_wrErr    <= dma_we && !w_dmaInRange;
                    r_memLoad  <= 1'b0;
                    r_state    <= ACK;
                end
                ACK: begin
                    r_cpuAck <= 1'b0;
                    r_dmaAck <= 1'b0;
                    r_wrErr  <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cpu_ack   = r_cpuAck;
    assign dma_ack   = r_dmaAck;
    assign cpu_rdata = r_cpuRdata;
    assign dma_rdata = r_dmaRdata;
    assign mem_addr  = r_memAddr;
    assign mem_in    = r_memIn;
    assign mem_load  = r_memLoad;
    assign wr_err    = r_wrErr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: scripted requesters plus a transaction-level model that predicts
// per-cycle acks, grants, write enables and read data from the arbitration rules.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int RO_BASE    = 24576;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [14:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [14:0] dma_addr = '0;
    logic [15:0] dma_wdata = '0;
    logic        dma_ack;
    logic [15:0] dma_rdata;
    logic [14:0] mem_addr;
    logic [15:0] mem_in;
    logic        mem_load;
    logic [15:0] mem_out;
    logic        wr_err;

    mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_in(mem_in), .mem_load(mem_load), .mem_out(mem_out),
        .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    // Shared store seen by the DUT: combinational read, write on the clock edge.
    logic [15:0] store [0:32767];
    assign mem_out = store[mem_addr];
    always @(posedge clk) begin
        if (mem_load) store[mem_addr] <= mem_in;
    end

    typedef struct {
        logic        we;
        logic [14:0] addr;
        logic [15:0] wdata;
        int          delay;
    } txn_t;

    typedef struct packed {
        logic        load;
        logic        ackC;
        logic        ackD;
        logic        err;
        logic        addrChk;
        logic [14:0] addr;
        logic [15:0] wdata;
        logic [15:0] rd;
    } exp_t;

    txn_t        cpuQ[$];
    txn_t        dmaQ[$];
    txn_t        cpuCur, dmaCur;
    logic        cpuActive = 1'b0, dmaActive = 1'b0;
    exp_t        recs [0:3];
    logic [15:0] refMem [0:32767];
    logic [15:0] expCpuRd = '0, expDmaRd = '0;
    int          cycle = 0, freeAt = 0, starve = 0;
    int          compared = 0, mismatched = 0;
    int          lastDmaAck = -1000, dmaGap = 0;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " cpu_ack"}, {15'd0, cpu_ack}, 16'd0);
        checkOutput({tag, " dma_ack"}, {15'd0, dma_ack}, 16'd0);
        checkOutput({tag, " wr_err"}, {15'd0, wr_err}, 16'd0);
        checkOutput({tag, " mem_load"}, {15'd0, mem_load}, 16'd0);
        checkOutput({tag, " cpu_rdata"}, cpu_rdata, 16'd0);
        checkOutput({tag, " dma_rdata"}, dma_rdata, 16'd0);
        checkOutput({tag, " mem_addr"}, {1'b0, mem_addr}, 16'd0);
        checkOutput({tag, " mem_in"}, mem_in, 16'd0);
    endtask

    task automatic clearRecs();
        for (int i = 0; i < 4; i++) recs[i] = '0;
    endtask

    // Compare this cycle's outputs with what the model scheduled for it.
    task automatic checkCycle(output logic ackC, output logic ackD);
        exp_t rec;
        rec = recs[cycle & 3];
        if (rec.ackC) expCpuRd = rec.rd;
        if (rec.ackD) expDmaRd = rec.rd;
        checkOutput("cpu_ack", {15'd0, cpu_ack}, {15'd0, rec.ackC});
        checkOutput("dma_ack", {15'd0, dma_ack}, {15'd0, rec.ackD});
        checkOutput("wr_err", {15'd0, wr_err}, {15'd0, rec.err});
        checkOutput("mem_load", {15'd0, mem_load}, {15'd0, rec.load});
        checkOutput("cpu_rdata", cpu_rdata, expCpuRd);
        checkOutput("dma_rdata", dma_rdata, expDmaRd);
        if (rec.addrChk) begin
            checkOutput("mem_addr", {1'b0, mem_addr}, {1'b0, rec.addr});
            checkOutput("mem_in", mem_in, rec.wdata);
        end
        if (dma_ack) begin
            dmaGap     = cycle - lastDmaAck;
            lastDmaAck = cycle;
        end
        ackC = rec.ackC;
        ackD = rec.ackD;
        recs[cycle & 3] = '0;
    endtask

    // Requesters hold a transaction until its ack, then take the next queued one after its delay.
    task automatic applyStimulus(input logic ackC, input logic ackD);
        txn_t t;
        if (ackC) cpuActive = 1'b0;
        if (ackD) dmaActive = 1'b0;
        if (!cpuActive && cpuQ.size() > 0) begin
            t = cpuQ[0];
            if (t.delay > 0) begin
                t.delay--;
                cpuQ[0] = t;
            end else begin
                cpuCur = cpuQ.pop_front();
                cpuActive = 1'b1;
            end
        end
        if (!dmaActive && dmaQ.size() > 0) begin
            t = dmaQ[0];
            if (t.delay > 0) begin
                t.delay--;
                dmaQ[0] = t;
            end else begin
                dmaCur = dmaQ.pop_front();
                dmaActive = 1'b1;
            end
        end
        cpu_req = cpuActive; cpu_we = cpuCur.we; cpu_addr = cpuCur.addr; cpu_wdata = cpuCur.wdata;
        dma_req = dmaActive; dma_we = dmaCur.we; dma_addr = dmaCur.addr; dma_wdata = dmaCur.wdata;
    endtask

    // When the arbiter is free this cycle, decide the winner and schedule the grant and ack cycles.
    task automatic arbitrate();
        txn_t t;
        logic useDma, legal;
        if (cycle >= freeAt && (cpuActive || dmaActive)) begin
            useDma = dmaActive && (!cpuActive || starve == STARVE_MAX);
            t      = useDma ? dmaCur : cpuCur;
            legal  = t.we && (int'(t.addr) < RO_BASE);
            recs[(cycle + 1) & 3].load    = legal;
            recs[(cycle + 1) & 3].addrChk = 1'b1;
            recs[(cycle + 1) & 3].addr    = t.addr;
            recs[(cycle + 1) & 3].wdata   = t.wdata;
            recs[(cycle + 2) & 3].ackC    = !useDma;
            recs[(cycle + 2) & 3].ackD    = useDma;
            recs[(cycle + 2) & 3].err     = t.we && !legal;
            recs[(cycle + 2) & 3].rd      = refMem[t.addr];
            if (legal) refMem[t.addr] = t.wdata;
            if (useDma) starve = 0;
            else if (dmaActive && starve < STARVE_MAX) starve++;
            freeAt = cycle + 3;
        end
    endtask

    task automatic stepCycle();
        logic ackC, ackD;
        @(negedge clk);
        cycle++;
        checkCycle(ackC, ackD);
        applyStimulus(ackC, ackD);
        arbitrate();
    endtask

    task automatic runUntilIdle(input string name, input int budget);
        int n = 0;
        while ((cpuActive || dmaActive || cpuQ.size() > 0 || dmaQ.size() > 0 || cycle < freeAt) && n < budget) begin
            stepCycle();
            n++;
        end
        if (n >= budget) checkOutput({name, " timeout"}, 16'd1, 16'd0);
    endtask

    function automatic txn_t mk(input logic we, input int addr, input logic [15:0] wdata, input int delay);
        txn_t t;
        t.we = we; t.addr = 15'(addr); t.wdata = wdata; t.delay = delay;
        return t;
    endfunction

    initial begin
        int a;
        for (int i = 0; i < 32768; i++) begin
            a = int'($urandom_range(0, 65535));
            store[i]  <= 16'(a);
            refMem[i] = 16'(a);
        end
        clearRecs();
        cpuCur = mk(1'b0, 0, 16'd0, 0);
        dmaCur = mk(1'b0, 0, 16'd0, 0);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) stepCycle();

        // CPU write then read back at the same address.
        cpuQ.push_back(mk(1'b1, 5, 16'h1234, 0));
        cpuQ.push_back(mk(1'b0, 5, 16'h0000, 0));
        runUntilIdle("cpu_wr_rd", 50);
        checkOutput("cpu_readback", cpu_rdata, 16'h1234);

        // Both requesters held: four CPU grants then one DMA, DMA acks 15 cycles apart.
        for (int i = 0; i < 10; i++) cpuQ.push_back(mk(1'b0, 100 + i, 16'd0, 0));
        for (int i = 0; i < 2; i++) dmaQ.push_back(mk(1'b0, 200 + i, 16'd0, 0));
        lastDmaAck = -1000;
        runUntilIdle("starve", 200);
        checkOutput("dma_ack_spacing", 16'(dmaGap), 16'd15);

        // DMA write to the first read-only address is dropped.
        dmaQ.push_back(mk(1'b1, 24576, 16'hFFFF, 0));
        runUntilIdle("dma_ro_write", 50);

        // DMA read of a preset location leaves CPU read data untouched.
        store[16384]  <= 16'hA5A5;
        refMem[16384] = 16'hA5A5;
        dmaQ.push_back(mk(1'b0, 16384, 16'd0, 1));
        runUntilIdle("dma_read", 50);
        checkOutput("dma_read_value", dma_rdata, 16'hA5A5);

        // Last writable address.
        cpuQ.push_back(mk(1'b1, 24575, 16'hBEEF, 0));
        runUntilIdle("cpu_top_write", 50);

        // Reset in the middle of a CPU grant: access aborted, request re-granted after release.
        cpuQ.push_back(mk(1'b0, 300, 16'd0, 0));
        for (int n = 0; n < 20 && !(cpuActive && cycle == freeAt - 2); n++) stepCycle();
        checkOutput("reset_reached_grant", {15'd0, cpuActive}, 16'd1);
        #2 rst_n = 1'b0;
        #1 checkAllZero("async_reset");
        clearRecs();
        starve   = 0;
        expCpuRd = '0;
        expDmaRd = '0;
        freeAt   = 32'h7fffffff;
        stepCycle();
        rst_n  = 1'b1;
        freeAt = cycle;
        arbitrate();
        runUntilIdle("after_reset", 50);

        // Random traffic from both requesters, including read-only and boundary addresses.
        for (int i = 0; i < 80; i++) begin
            for (int k = 0; k < 2; k++) begin
                int sel, addr;
                sel = int'($urandom_range(0, 3));
                case (sel)
                    0: addr = int'($urandom_range(0, 24575));
                    1: addr = 24575 + int'($urandom_range(0, 1));
                    2: addr = int'($urandom_range(24576, 32767));
                    default: addr = int'($urandom_range(0, 15));
                endcase
                if (k == 0) cpuQ.push_back(mk(1'($urandom_range(0, 1)), addr, 16'($urandom), int'($urandom_range(0, 4))));
                else        dmaQ.push_back(mk(1'($urandom_range(0, 1)), addr, 16'($urandom), int'($urandom_range(0, 4))));
            end
        end
        runUntilIdle("random", 10000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
